// File: rtl/fifo_driver.sv
// Command-side initiator for the command-driven FIFO: arbitrates a write stream and a
// read stream into single PUSH/POP commands, tracks occupancy and flags non-response.
module fifo_driver #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_valid,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_wr_ready,
    output logic                       o_rd_valid,
    output logic [WIDTH-1:0]           o_rd_data,
    input  logic                       i_rd_ready,
    output logic                       o_enable,
    output logic [1:0]                 o_cmd,
    output logic [WIDTH-1:0]           o_fifo_data,
    input  logic [WIDTH-1:0]           i_fifo_data,
    input  logic                       i_done,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_error
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PUSH = 2'd1,
        WAIT_POP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2
    } cmd_e;

    state_e            state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic              enable_q;
    logic [WIDTH-1:0]  fifo_data_q, fifo_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              error_q, error_d;
    logic              last_pop_q, last_pop_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic              push_ok, pop_ok, wr_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_NONE;
            enable_q    <= 1'b0;
            fifo_data_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            error_q     <= 1'b0;
            last_pop_q  <= 1'b1;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            enable_q    <= 1'b1;
            fifo_data_q <= fifo_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            error_q     <= error_d;
            last_pop_q  <= last_pop_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = CMD_NONE;
        fifo_data_d = fifo_data_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        count_d     = count_q;
        error_d     = error_q;
        last_pop_d  = last_pop_q;
        wait_d      = wait_q;
        wr_ready    = 1'b0;
        push_ok     = i_wr_valid && !full_q;
        pop_ok      = !empty_q && !rd_valid_q;

        if (rd_valid_q && i_rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                wait_d = '0;
                // When both sides are eligible, serve the one not served last time.
                if (push_ok && (!pop_ok || last_pop_q)) begin
                    wr_ready    = 1'b1;
                    cmd_d       = CMD_PUSH;
                    fifo_data_d = i_wr_data;
                    state_d     = WAIT_PUSH;
                end else if (pop_ok) begin
                    cmd_d   = CMD_POP;
                    state_d = WAIT_POP;
                end
            end
            WAIT_PUSH, WAIT_POP: begin
                wait_d = wait_q + TW'(1);
                if (i_done) begin
                    state_d = IDLE;
                    if (state_q == WAIT_PUSH) begin
                        count_d    = count_q + CW'(1);
                        last_pop_d = 1'b0;
                    end else begin
                        rd_data_d  = i_fifo_data;
                        rd_valid_d = 1'b1;
                        count_d    = count_q - CW'(1);
                        last_pop_d = 1'b1;
                    end
                end else if (wait_q == T_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    assign o_wr_ready  = wr_ready && !i_reset;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_enable    = enable_q;
    assign o_cmd       = cmd_q;
    assign o_fifo_data = fifo_data_q;
    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_fifo_driver.sv
// Directed bench for fifo_driver with a small command-driven FIFO peer model.
module tb_fifo_driver;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int T  = 5;
    localparam int CW = $clog2(D + 1);

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_wr_valid;
    logic [W-1:0]  i_wr_data;
    logic          o_wr_ready;
    logic          o_rd_valid;
    logic [W-1:0]  o_rd_data;
    logic          i_rd_ready;
    logic          o_enable;
    logic [1:0]    o_cmd;
    logic [W-1:0]  o_fifo_data;
    logic [W-1:0]  i_fifo_data;
    logic          i_done;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_error;

    int checks = 0;
    int errors = 0;

    logic          model_done;
    logic          stray_done;
    logic          fifo_alive;
    logic [W-1:0]  mem[$];
    logic          log_en;
    logic [1:0]    cmd_log[$];
    logic [W-1:0]  pop_log[$];

    fifo_driver #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_enable(o_enable), .o_cmd(o_cmd), .o_fifo_data(o_fifo_data),
        .i_fifo_data(i_fifo_data), .i_done(i_done),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    // FIFO peer: answers each command with a one-cycle done on the following cycle.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            model_done  <= 1'b0;
            i_fifo_data <= '0;
            mem.delete();
        end else begin
            model_done <= 1'b0;
            if (fifo_alive && o_enable) begin
                if (o_cmd == 2'd1) begin
                    mem.push_back(o_fifo_data);
                    model_done <= 1'b1;
                end else if (o_cmd == 2'd2) begin
                    if (mem.size() > 0) i_fifo_data <= mem.pop_front();
                    model_done <= 1'b1;
                end
            end
        end
    end

    assign i_done = model_done | stray_done;

    always @(negedge i_clk) begin
        if (log_en) begin
            if (o_cmd != 2'd0) cmd_log.push_back(o_cmd);
            if (o_rd_valid && i_rd_ready) pop_log.push_back(o_rd_data);
        end
    end

    task automatic do_reset();
        i_reset    = 1'b1;
        i_wr_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    // Holds the word until accepted; returns at the negedge of the issue cycle.
    task automatic push_word(input logic [W-1:0] d, input int budget, output bit accepted);
        accepted   = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        for (int i = 0; i < budget && !accepted; i++) begin
            #1;
            if (o_wr_ready) accepted = 1'b1;
            @(negedge i_clk);
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_wr_valid = 1'b1; i_wr_data = 8'h5A; i_rd_ready = 1'b0;
        stray_done = 1'b0; fifo_alive = 1'b1; log_en = 1'b0;
        #12;
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %0h expected 0", o_enable); end
        checks++; if (o_cmd !== 2'd0) begin errors++; $display("FAIL rst_cmd: got %0h expected 0", o_cmd); end
        checks++; if (o_fifo_data !== 8'h00) begin errors++; $display("FAIL rst_fifo_data: got %0h expected 0", o_fifo_data); end
        checks++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd: got valid %0h data %0h expected 0 0", o_rd_valid, o_rd_data); end
        checks++; if (o_count !== 3'd0 || o_full !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL rst_flags: got count %0d full %0h empty %0h expected 0 0 1", o_count, o_full, o_empty); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %0h expected 0", o_error); end
        checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %0h expected 0", o_wr_ready); end
        @(negedge i_clk);
        i_reset = 1'b0; i_wr_valid = 1'b0;
        @(negedge i_clk);
        checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL enable_after_reset: got %0h expected 1", o_enable); end
        stray_done = 1'b1;
        @(negedge i_clk);
        stray_done = 1'b0;
        @(negedge i_clk);
        checks++; if (o_count !== 3'd0 || o_rd_valid !== 1'b0 || o_cmd !== 2'd0) begin errors++; $display("FAIL stray_done: got count %0d rd_valid %0h cmd %0h expected 0 0 0", o_count, o_rd_valid, o_cmd); end
    endtask

    task automatic test_push_pop();
        bit acc;
        i_rd_ready = 1'b1;
        push_word(8'hA5, 5, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL pp_accept: got %0h expected 1", acc); end
        checks++; if (o_cmd !== 2'd1 || o_fifo_data !== 8'hA5) begin errors++; $display("FAIL pp_push_cmd: got cmd %0h data %0h expected 1 a5", o_cmd, o_fifo_data); end
        @(negedge i_clk);
        checks++; if (o_cmd !== 2'd0) begin errors++; $display("FAIL pp_cmd_none: got %0h expected 0", o_cmd); end
        @(negedge i_clk);
        checks++; if (o_count !== 3'd1 || o_empty !== 1'b0) begin errors++; $display("FAIL pp_count1: got count %0d empty %0h expected 1 0", o_count, o_empty); end
        @(negedge i_clk);
        checks++; if (o_cmd !== 2'd2) begin errors++; $display("FAIL pp_pop_cmd: got %0h expected 2", o_cmd); end
        @(negedge i_clk);
        @(negedge i_clk);
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5) begin errors++; $display("FAIL pp_rd: got valid %0h data %0h expected 1 a5", o_rd_valid, o_rd_data); end
        checks++; if (o_count !== 3'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL pp_count0: got count %0d empty %0h expected 0 1", o_count, o_empty); end
        @(negedge i_clk);
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL pp_rd_clear: got %0h expected 0", o_rd_valid); end
    endtask

    // Word 1 is pushed then popped into the stalled read slot; 2..5 fill the FIFO.
    task automatic test_fill();
        bit acc;
        do_reset();
        i_rd_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            push_word(W'(w), 20, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL fill_accept_%0d: got %0h expected 1", w, acc); end
        end
        push_word(8'd6, 10, acc);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL fill_block_6: got %0h expected 0", acc); end
        checks++; if (o_count !== 3'd4 || o_full !== 1'b1 || o_empty !== 1'b0) begin errors++; $display("FAIL fill_flags: got count %0d full %0h empty %0h expected 4 1 0", o_count, o_full, o_empty); end
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'd1) begin errors++; $display("FAIL fill_rd: got valid %0h data %0h expected 1 1", o_rd_valid, o_rd_data); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            checks++; if (o_cmd === 2'd2 || o_rd_data !== 8'd1) begin errors++; $display("FAIL bp_hold_%0d: got cmd %0h data %0h expected cmd!=2 data 1", c, o_cmd, o_rd_data); end
        end
        i_rd_ready = 1'b1;
        @(negedge i_clk);
        i_rd_ready = 1'b0;
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0h expected 0", o_rd_valid); end
        @(negedge i_clk);
        checks++; if (o_cmd !== 2'd2) begin errors++; $display("FAIL bp_pop_cmd: got %0h expected 2", o_cmd); end
        @(negedge i_clk);
        @(negedge i_clk);
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'd2) begin errors++; $display("FAIL bp_next: got valid %0h data %0h expected 1 2", o_rd_valid, o_rd_data); end
        checks++; if (o_count !== 3'd3 || o_full !== 1'b0) begin errors++; $display("FAIL bp_count: got count %0d full %0h expected 3 0", o_count, o_full); end
    endtask

    task automatic test_simultaneous();
        bit acc;
        logic [W-1:0] words[4];
        words = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        i_rd_ready = 1'b1;
        cmd_log.delete();
        pop_log.delete();
        log_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_word(words[i], 20, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL sim_accept_%0d: got %0h expected 1", i, acc); end
        end
        repeat (15) @(negedge i_clk);
        log_en = 1'b0;
        checks++; if (cmd_log.size() != 8) begin errors++; $display("FAIL sim_cmd_count: got %0d expected 8", cmd_log.size()); end
        for (int i = 0; i < cmd_log.size() && i < 8; i++) begin
            checks++; if (cmd_log[i] !== ((i % 2 == 0) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL sim_cmd_%0d: got %0h expected %0h", i, cmd_log[i], (i % 2 == 0) ? 1 : 2); end
        end
        checks++; if (pop_log.size() != 4) begin errors++; $display("FAIL sim_pop_count: got %0d expected 4", pop_log.size()); end
        for (int i = 0; i < pop_log.size() && i < 4; i++) begin
            checks++; if (pop_log[i] !== words[i]) begin errors++; $display("FAIL sim_pop_%0d: got %0h expected %0h", i, pop_log[i], words[i]); end
        end
    endtask

    task automatic test_timeout();
        bit acc;
        do_reset();
        i_rd_ready = 1'b0;
        fifo_alive = 1'b0;
        push_word(8'h11, 5, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL to_accept: got %0h expected 1", acc); end
        repeat (T - 1) @(negedge i_clk);
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL to_early: got %0h expected 0", o_error); end
        @(negedge i_clk);
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL to_error: got %0h expected 1", o_error); end
        checks++; if (o_count !== 3'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL to_count: got count %0d empty %0h expected 0 1", o_count, o_empty); end
        fifo_alive = 1'b1;
        push_word(8'h22, 1, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL to_idle_accept: got %0h expected 1", acc); end
        repeat (2) @(negedge i_clk);
        checks++; if (o_count !== 3'd1 || o_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got count %0d error %0h expected 1 1", o_count, o_error); end
        repeat (3) @(negedge i_clk);
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h22 || o_count !== 3'd0) begin errors++; $display("FAIL to_pop: got valid %0h data %0h count %0d expected 1 22 0", o_rd_valid, o_rd_data, o_count); end
    endtask

    task automatic test_async_reset();
        bit acc;
        bit found;
        i_rd_ready = 1'b1;
        push_word(8'h77, 10, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL ar_accept: got %0h expected 1", acc); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge i_clk);
            if (o_cmd == 2'd2) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL ar_wait_pop: got %0h expected 1", found); end
        #1 i_reset = 1'b1;
        #1;
        checks++; if (o_enable !== 1'b0 || o_cmd !== 2'd0 || o_fifo_data !== 8'h00) begin errors++; $display("FAIL ar_cmd: got en %0h cmd %0h data %0h expected 0 0 0", o_enable, o_cmd, o_fifo_data); end
        checks++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h00 || o_wr_ready !== 1'b0) begin errors++; $display("FAIL ar_rd: got valid %0h data %0h wr_ready %0h expected 0 0 0", o_rd_valid, o_rd_data, o_wr_ready); end
        checks++; if (o_count !== 3'd0 || o_full !== 1'b0 || o_empty !== 1'b1 || o_error !== 1'b0) begin errors++; $display("FAIL ar_flags: got count %0d full %0h empty %0h error %0h expected 0 0 1 0", o_count, o_full, o_empty, o_error); end
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (4) @(negedge i_clk);
        checks++; if (o_rd_valid !== 1'b0 || o_count !== 3'd0 || o_empty !== 1'b1 || o_cmd !== 2'd0) begin errors++; $display("FAIL ar_after: got valid %0h count %0d empty %0h cmd %0h expected 0 0 1 0", o_rd_valid, o_count, o_empty, o_cmd); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill();
        test_backpressure();
        test_simultaneous();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
